// File: rtl/light_switch_debounce.sv
// Two-channel switch conditioner: synchronizes and debounces raw switch levels
// and emits one-cycle change strobes per channel plus a combined event strobe.

module light_switch_debounce_chan #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic chg_o,
  output logic accept_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             chg_q;
  state_e           state_s;
  logic             differ_s;
  logic             accept_s;

  // The state is not stored separately: a non-zero counter means a candidate
  // level is being qualified.
  assign state_s  = (cnt_q == CNT_ZERO) ? ST_IDLE : ST_COUNT;
  assign differ_s = (sync2_q != level_q);
  assign accept_s = (state_s == ST_COUNT) && differ_s && (cnt_q == CNT_LAST);

  // Two-flop synchronizer for the asynchronous raw level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a new level must differ from the accepted one for
  // DB_CYCLES consecutive clocks; any return to the old level restarts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      case (state_s)
        ST_IDLE: begin
          if (differ_s) begin
            cnt_q <= CNT_ONE;
          end else begin
            cnt_q <= CNT_ZERO;
          end
        end
        ST_COUNT: begin
          if (!differ_s) begin
            cnt_q <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            level_q <= sync2_q;
            chg_q   <= 1'b1;
            cnt_q   <= CNT_ZERO;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q <= CNT_ZERO;
        end
      endcase
    end
  end

  assign level_o  = level_q;
  assign chg_o    = chg_q;
  assign accept_o = accept_s;

endmodule

module light_switch_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw1_raw,
  input  logic sw2_raw,
  output logic x1,
  output logic x2,
  output logic x1_chg,
  output logic x2_chg,
  output logic sw_event
);

  logic x1_accept_s;
  logic x2_accept_s;
  logic sw_event_q;

  light_switch_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_ch1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .raw_i    (sw1_raw),
    .level_o  (x1),
    .chg_o    (x1_chg),
    .accept_o (x1_accept_s)
  );

  light_switch_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_ch2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .raw_i    (sw2_raw),
    .level_o  (x2),
    .chg_o    (x2_chg),
    .accept_o (x2_accept_s)
  );

  // Combined strobe is registered from the acceptance terms so it lines up
  // with the per-channel strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_event_q <= 1'b0;
    end else begin
      sw_event_q <= x1_accept_s | x2_accept_s;
    end
  end

  assign sw_event = sw_event_q;

endmodule
